// File: rtl/frac_strobe_generator.sv
// Multi-channel fractional clock-enable generator.
// Each channel adds its increment into a phase accumulator every cycle it is enabled;
// the carry out of the add becomes a registered one-cycle strobe and toggles a divided
// clock. New increments land in a per-channel shadow and are applied only when the
// channel wraps (or while it is disabled), so a retune never produces a runt period.
// Optional feature: define FSG_PHASE_OUT_EN to expose the raw accumulators on `phase`.
module frac_strobe_generator #(
  parameter int unsigned       NUM_CH      = 2,
  parameter int unsigned       ACC_W       = 16,
  parameter logic [ACC_W-1:0]  DEFAULT_INC = ACC_W'(16'h338F),
  localparam int unsigned      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    systemClk,
  input  logic                    rstN,
  input  logic [NUM_CH-1:0]       chEn,
  input  logic                    wrValid,
  output logic                    wrReady,
  input  logic [CH_W-1:0]         wrCh,
  input  logic [ACC_W-1:0]        wrInc,
  output logic [NUM_CH-1:0]       stb,
  output logic [NUM_CH-1:0]       clkOut,
  output logic [NUM_CH-1:0]       pending
`ifdef FSG_PHASE_OUT_EN
  ,
  output logic [NUM_CH*ACC_W-1:0] phase
`endif
);

  logic [ACC_W-1:0]  acc_q    [NUM_CH];
  logic [ACC_W-1:0]  acc_d    [NUM_CH];
  logic [ACC_W-1:0]  inc_q    [NUM_CH];
  logic [ACC_W-1:0]  inc_d    [NUM_CH];
  logic [ACC_W-1:0]  shadow_q [NUM_CH];
  logic [ACC_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] stb_q, stb_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;

  logic [NUM_CH-1:0] wr_sel;
  logic              wr_accept;

  // Decode the write target; an out-of-range channel selects nothing, so the write is
  // accepted (ready stays high) and dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = (wrCh == CH_W'(i));
    end
  end

  // Ready only while the targeted channel has no unapplied shadow value.
  always_comb begin
    wrReady   = ~|(wr_sel & pend_q);
    wr_accept = wrValid & wrReady;
  end

  // Per-channel accumulate, carry detect, shadow apply and shadow load.
  always_comb begin
    logic [ACC_W:0] sum;
    sum       = '0;
    pend_d    = pend_q;
    stb_d     = stb_q;
    clk_out_d = clk_out_q;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i]    = acc_q[i];
      inc_d[i]    = inc_q[i];
      shadow_d[i] = shadow_q[i];
      sum         = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      if (chEn[i]) begin
        acc_d[i] = sum[ACC_W-1:0];
        stb_d[i] = sum[ACC_W];
        if (sum[ACC_W]) begin
          clk_out_d[i] = ~clk_out_q[i];
          // Swap increments only on a wrap so the current period completes normally.
          if (pend_q[i]) begin
            inc_d[i]  = shadow_q[i];
            pend_d[i] = 1'b0;
          end
        end
      end else begin
        acc_d[i]     = '0;
        stb_d[i]     = 1'b0;
        clk_out_d[i] = 1'b0;
        // An idle channel has no period to protect, so apply immediately.
        if (pend_q[i]) begin
          inc_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
      end
      // Accept implies pend_q was clear, so this never collides with an apply above.
      if (wr_accept && wr_sel[i]) begin
        shadow_d[i] = wrInc;
        pend_d[i]   = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge systemClk) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]    <= '0;
        inc_q[i]    <= DEFAULT_INC;
        shadow_q[i] <= DEFAULT_INC;
      end
      pend_q    <= '0;
      stb_q     <= '0;
      clk_out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]    <= acc_d[i];
        inc_q[i]    <= inc_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      pend_q    <= pend_d;
      stb_q     <= stb_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign stb     = stb_q;
  assign clkOut  = clk_out_q;
  assign pending = pend_q;

`ifdef FSG_PHASE_OUT_EN
  // Raw accumulators, channel 0 in the LSBs.
  always_comb begin
    phase = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      phase[i*ACC_W +: ACC_W] = acc_q[i];
    end
  end
`endif

endmodule
